// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Up/down counter over the range 0..MAX_VAL with parallel load, synchronous
//   clear, terminal-count detection, a one-cycle bound-event pulse and a sticky
//   overflow/underflow flag. It either wraps or saturates at the bounds.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX_VAL   highest count value (< 2**WIDTH)
//   SATURATE  0 = wrap at bounds, 1 = hold at bounds
//   RST_VAL   count after reset or clear (<= MAX_VAL)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   clr       synchronous clear (highest priority)
//   en        count enable (lowest priority)
//   load      synchronous parallel load
//   load_val  load value, clamped to MAX_VAL
//   up        direction: 1 = increment, 0 = decrement
//   ovf_clr   clears the sticky ovf flag
//   count     current count (registered)
//   tc        terminal count for the current direction (combinational)
//   wrap_p    registered pulse, high the cycle after a bound event
//   ovf       sticky bound-event flag (registered)
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_p,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam bit               SatMode  = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             bound;

    always_comb begin
        count_d = count_q;
        bound   = 1'b0;
        if (clr) begin
            count_d = RstCount;
        end else if (load) begin
            count_d = (load_val > MaxCount) ? MaxCount : load_val;
        end else if (en) begin
            if (up) begin
                if (count_q == MaxCount) begin
                    bound   = 1'b1;
                    count_d = SatMode ? MaxCount : '0;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (count_q == '0) begin
                    bound   = 1'b1;
                    count_d = SatMode ? '0 : MaxCount;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    // bound can only be raised on the enable path, so clr/load already mask it.
    always_comb begin
        wrap_d = bound;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (bound) begin
            ovf_d = 1'b1;  // a set beats a simultaneous ovf_clr
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RstCount;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count  = count_q;
    assign wrap_p = wrap_q;
    assign ovf    = ovf_q;
    assign tc     = (up & (count_q == MaxCount)) | (~up & (count_q == '0));

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clr, en, load, up, ovf_clr;
    logic [3:0] load_val;

    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

    int checks   = 0;
    int failures = 0;

    // Hand-computed sequences for 12 up-count edges starting from 0.
    int exp_cw [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_pw [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_ow [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int exp_cs [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int exp_ps [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_ts [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    // Up-count for 5 edges starting from 7.
    int exp_c7w [5] = '{8, 9, 0, 1, 2};
    int exp_p7w [5] = '{0, 0, 1, 0, 0};
    int exp_c7s [5] = '{8, 9, 9, 9, 9};
    int exp_p7s [5] = '{0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(0)) dut_w (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .load_val(load_val),
        .up(up), .ovf_clr(ovf_clr), .count(count_w), .tc(tc_w), .wrap_p(wrap_w), .ovf(ovf_w)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RST_VAL(0)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .load_val(load_val),
        .up(up), .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s), .wrap_p(wrap_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input int cw, input int pw, input int ow,
                           input int cs, input int ps, input int os);
        chk({tag, " count_w"}, 32'(count_w), cw);
        chk({tag, " wrap_w"},  32'(wrap_w),  pw);
        chk({tag, " ovf_w"},   32'(ovf_w),   ow);
        chk({tag, " count_s"}, 32'(count_s), cs);
        chk({tag, " wrap_s"},  32'(wrap_s),  ps);
        chk({tag, " ovf_s"},   32'(ovf_s),   os);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1;
        ovf_clr = 1'b0; load_val = 4'd0;

        // Reset state and combinational tc in both directions.
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        chk("reset tc_up", 32'(tc_w), 0);
        up = 1'b0;
        #1;
        chk("reset tc_down", 32'(tc_w), 1);

        // Test 1: count up 12 edges.
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_all("up12", exp_cw[i], exp_pw[i], exp_ow[i], exp_cs[i], exp_ps[i], exp_ow[i]);
            chk("up12 tc_w", 32'(tc_w), exp_tw[i]);
            chk("up12 tc_s", 32'(tc_s), exp_ts[i]);
        end

        // Clear overrides a pending bound event on the saturating counter.
        clr = 1'b1;
        step();
        chk_all("clr", 0, 0, 0, 0, 0, 0);
        clr = 1'b0;

        // Test 2: down from 0 wraps / holds, then ovf_clr.
        up = 1'b0;
        step();
        chk_all("down_bound", 9, 1, 1, 0, 1, 1);
        en = 1'b0; ovf_clr = 1'b1;
        step();
        chk_all("ovf_clr", 9, 0, 0, 0, 0, 0);
        chk("hold tc_w", 32'(tc_w), 0);
        chk("hold tc_s", 32'(tc_s), 1);

        // Test 5: ovf_clr with a simultaneous bound event on the saturating counter.
        en = 1'b1;
        step();
        chk_all("set_vs_clr", 8, 0, 0, 0, 1, 1);
        en = 1'b0;
        step();
        chk_all("ovf_clr2", 8, 0, 0, 0, 0, 0);
        ovf_clr = 1'b0;

        // Test 4: load clamps and suppresses the bound event from en.
        load = 1'b1; load_val = 4'd13; en = 1'b1; up = 1'b0;
        step();
        chk_all("load_clamp", 9, 0, 0, 9, 0, 0);
        load_val = 4'd5;
        step();
        chk_all("load_5", 5, 0, 0, 5, 0, 0);
        clr = 1'b1;
        step();
        chk_all("clr_load", 0, 0, 0, 0, 0, 0);
        clr = 1'b0;

        // Test 3: count up from 7 for 5 edges.
        load_val = 4'd7; en = 1'b0;
        step();
        chk_all("load_7", 7, 0, 0, 7, 0, 0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("up7", exp_c7w[i], exp_p7w[i], (i >= 2) ? 1 : 0,
                    exp_c7s[i], exp_p7s[i], (i >= 2) ? 1 : 0);
        end

        // Idle edge holds count and ovf.
        en = 1'b0;
        step();
        chk_all("idle", 2, 0, 1, 9, 0, 1);

        // Test 6: asynchronous reset between edges at count 5.
        load = 1'b1; load_val = 4'd5;
        step();
        chk_all("pre_rst", 5, 0, 1, 5, 0, 1);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        en = 1'b1; up = 1'b1;
        step();
        chk_all("post_rst", 1, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
